// File: rtl/div_seq_sgn_if.sv
// Start/ready/done_tick handshake and result bus of the sequential signed/unsigned divider.
interface div_seq_sgn_if #(
    parameter int unsigned W = 16
) ();
    logic         start;
    logic         sgn;
    logic [W-1:0] dvnd;
    logic [W-1:0] dvsr;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] quo;
    logic [W-1:0] rmd;
    logic         dbz;
    logic         ovf;

    modport master (
        output start, sgn, dvnd, dvsr,
        input  ready, done_tick, quo, rmd, dbz, ovf
    );

    modport slave (
        input  start, sgn, dvnd, dvsr,
        output ready, done_tick, quo, rmd, dbz, ovf
    );
endinterface

// File: rtl/div_seq_sgn.sv
// Multi-cycle restoring divider with signed/unsigned mode, dbz/ovf flags and held results.
// Optional macro DIV_SEQ_DBZ_FAST_EN: divide-by-zero completes straight from IDLE.
module div_seq_sgn #(
    parameter int unsigned W = 16
) (
    input logic         clk,
    input logic         reset_n,
    div_seq_sgn_if.slave bus
);
    localparam int unsigned CBIT = $clog2(W + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOp   = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [CBIT-1:0] CntInit = CBIT'(W);
    localparam logic [CBIT-1:0] CntOne  = CBIT'(1);
    localparam logic [W-1:0]    MinNeg  = {1'b1, {(W-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CBIT-1:0] cnt_q, cnt_d;
    logic            sgn_q, sgn_d;
    logic            dneg_q, dneg_d;
    logic            vneg_q, vneg_d;
    logic            ovfp_q, ovfp_d;
    logic [W-1:0]    rh_q, rh_d;
    logic [W-1:0]    rl_q, rl_d;
    logic [W-1:0]    d_q, d_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rmd_q, rmd_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    // Shifted partial remainder carries the bit pushed out of rh, so no carry is lost.
    logic [W:0] shl;
    logic [W:0] diff;
    logic       ge;

    assign shl  = {rh_q, rl_q[W-1]};
    assign diff = shl - {1'b0, d_q};
    assign ge   = (shl >= {1'b0, d_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        dneg_d  = dneg_q;
        vneg_d  = vneg_q;
        ovfp_d  = ovfp_q;
        rh_d    = rh_q;
        rl_d    = rl_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sgn_d   = bus.sgn;
                    dneg_d  = bus.sgn & bus.dvnd[W-1];
                    vneg_d  = bus.sgn & bus.dvsr[W-1];
                    ovfp_d  = bus.sgn && (bus.dvnd == MinNeg) && (bus.dvsr == '1);
                    rl_d    = (bus.sgn && bus.dvnd[W-1]) ? -bus.dvnd : bus.dvnd;
                    d_d     = (bus.sgn && bus.dvsr[W-1]) ? -bus.dvsr : bus.dvsr;
                    rh_d    = '0;
                    cnt_d   = CntInit;
                    state_d = StOp;
`ifdef DIV_SEQ_DBZ_FAST_EN
                    if (bus.dvsr == '0) begin
                        quo_d   = '1;
                        rmd_d   = bus.dvnd;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = StDone;
                    end
`endif
                end
            end
            StOp: begin
                rh_d  = ge ? diff[W-1:0] : shl[W-1:0];
                rl_d  = {rl_q[W-2:0], ge};
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // Truncating division: quotient sign from sign mismatch, remainder from dividend.
                quo_d   = (sgn_q && (dneg_q ^ vneg_q)) ? -rl_q : rl_q;
                rmd_d   = (sgn_q && dneg_q) ? -rh_q : rh_q;
                dbz_d   = (d_q == '0);
                ovf_d   = ovfp_q;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            dneg_q  <= 1'b0;
            vneg_q  <= 1'b0;
            ovfp_q  <= 1'b0;
            rh_q    <= '0;
            rl_q    <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            dneg_q  <= dneg_d;
            vneg_q  <= vneg_d;
            ovfp_q  <= ovfp_d;
            rh_q    <= rh_d;
            rl_q    <= rl_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ready     = (state_q == StIdle);
    assign bus.done_tick = (state_q == StDone);
    assign bus.quo       = quo_q;
    assign bus.rmd       = rmd_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;
endmodule
